// File: rtl/twiddle_gen.sv
// Purpose: streams FFT twiddle factors W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) as fp16 pairs.
// Latency: first word valid 2 cycles after the accepted start; one word per cycle after that.
// Backpressure: the whole pipeline and the sequencer stall together while w_valid & !w_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                burst request, honoured only when idle and count != 0
//   k_start, k_step      first exponent and per-word increment (mod N)
//   count                words in the burst, 1..N
//   busy                 a burst is being issued or drained
//   w_valid/w_ready      output handshake for w_re, w_im, w_last
//   w_re, w_im           real / imaginary part, IEEE-754 half precision
//   w_last               final word of the burst
//   inv                  only with TWIDDLE_INVERSE_EN defined: 1 = emit conjugated twiddles
//
// Optional feature macro: TWIDDLE_INVERSE_EN (adds input inv, captured at start).
module twiddle_gen #(
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LOG2N-1:0] k_start,
    input  logic [LOG2N-1:0] k_step,
    input  logic [LOG2N:0]   count,
    output logic             busy,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [15:0]      w_re,
    output logic [15:0]      w_im,
    output logic             w_last
`ifdef TWIDDLE_INVERSE_EN
    ,
    input  logic             inv
`endif
);

    localparam int N     = 1 << LOG2N;
    localparam int QN    = N / 4;       // exponents per quadrant
    localparam int SH    = 6 - LOG2N;   // log2(64/N): ROM address scale
    localparam int CNT_W = LOG2N + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Quarter-wave table C[m] = cos(2*pi*m/64), m = 0..16, shared by every N.
    function automatic logic [15:0] cos_rom(input logic [4:0] m);
        logic [15:0] v;
        case (m)
            5'd0:    v = 16'h3C00;
            5'd1:    v = 16'h3BF6;
            5'd2:    v = 16'h3BD9;
            5'd3:    v = 16'h3BA8;
            5'd4:    v = 16'h3B64;
            5'd5:    v = 16'h3B0E;
            5'd6:    v = 16'h3AA7;
            5'd7:    v = 16'h3A2F;
            5'd8:    v = 16'h39A8;
            5'd9:    v = 16'h3913;
            5'd10:   v = 16'h3872;
            5'd11:   v = 16'h378B;
            5'd12:   v = 16'h361F;
            5'd13:   v = 16'h34A5;
            5'd14:   v = 16'h323E;
            5'd15:   v = 16'h2E46;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Sign flip; zero stays +0 so the stream never carries 0x8000.
    function automatic logic [15:0] fp_neg(input logic [15:0] x);
        return (x[14:0] == 15'd0) ? 16'h0000 : {~x[15], x[14:0]};
    endfunction

    state_t             state;
    logic [LOG2N-1:0]   k;
    logic [LOG2N-1:0]   step;
    logic [LOG2N:0]     remaining;
    logic               inv_r;

    logic               s1_vld;
    logic [1:0]         s1_q;
    logic [4:0]         s1_a;
    logic [4:0]         s1_b;
    logic               s1_last;

    logic               adv;
    logic               accept;
    logic               issue;
    logic [LOG2N-1:0]   k_cur;
    logic               last_cur;
    logic [LOG2N-3:0]   r_cur;
    logic [4:0]         a_cur;
    logic [4:0]         b_cur;
    logic [15:0]        ca;
    logic [15:0]        cb;
    logic [15:0]        fold_re;
    logic [15:0]        fold_im;

    assign adv    = !w_valid || w_ready;
    assign accept = (state == IDLE) && start && (count != '0);
    // The first exponent is issued in the start cycle itself so the first word
    // lands two cycles later; RUN issues the remaining count-1 exponents.
    assign issue  = accept || ((state == RUN) && (remaining != '0));

    assign k_cur    = accept ? k_start : k;
    assign last_cur = accept ? (count == CNT_W'(1)) : (remaining == CNT_W'(1));
    assign r_cur    = k_cur[LOG2N-3:0];
    assign a_cur    = 5'(r_cur) << SH;
    assign b_cur    = (5'(QN) - 5'(r_cur)) << SH;

    assign ca = cos_rom(s1_a);
    assign cb = cos_rom(s1_b);

    always_comb begin
        fold_re = 16'h0000;
        fold_im = 16'h0000;
        case (s1_q)
            2'd0: begin fold_re = ca;         fold_im = fp_neg(cb); end
            2'd1: begin fold_re = fp_neg(cb); fold_im = fp_neg(ca); end
            2'd2: begin fold_re = fp_neg(ca); fold_im = cb;         end
            default: begin fold_re = cb;      fold_im = ca;         end
        endcase
        if (inv_r) begin
            fold_im = fp_neg(fold_im);
        end
    end

`ifndef TWIDDLE_INVERSE_EN
    assign inv_r = 1'b0;
`endif

    // Sequencer. In IDLE the output stage is always empty (the last word has
    // just handshaken, or reset cleared it), so adv is high whenever start is
    // accepted and the first exponent is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            k         <= '0;
            step      <= '0;
            remaining <= '0;
`ifdef TWIDDLE_INVERSE_EN
            inv_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k         <= k_start + k_step;
                        step      <= k_step;
                        remaining <= count - CNT_W'(1);
`ifdef TWIDDLE_INVERSE_EN
                        inv_r     <= inv;
`endif
                        state     <= RUN;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (remaining == '0) begin
                        state <= DRAIN;             // single-word burst: nothing left to issue
                    end else if (adv) begin
                        k         <= k + step;      // wraps mod N by width
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_valid && w_ready && w_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage datapath: stage 1 holds quadrant and ROM addresses, stage 2 the
    // folded result, which drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_q    <= 2'd0;
            s1_a    <= 5'd0;
            s1_b    <= 5'd0;
            s1_last <= 1'b0;
            w_valid <= 1'b0;
            w_re    <= 16'h0000;
            w_im    <= 16'h0000;
            w_last  <= 1'b0;
        end else if (adv) begin
            s1_vld <= issue;
            if (issue) begin
                s1_q    <= k_cur[LOG2N-1 -: 2];
                s1_a    <= a_cur;
                s1_b    <= b_cur;
                s1_last <= last_cur;
            end
            w_valid <= s1_vld;
            w_last  <= s1_vld && s1_last;
            if (s1_vld) begin
                w_re <= fold_re;
                w_im <= fold_im;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Purpose: self-checking bench for twiddle_gen at N = 8, 16 and 64.
// Latency: expected words come from a trig model queued at start, popped on each handshake.
// Backpressure: w_ready is either held high or toggled 1,0,0,1 to exercise stalls.
module tb_twiddle_gen;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [5:0]  ks;
    logic [5:0]  kp;
    logic [6:0]  cnt;
    logic        w_ready;
    logic        inv_v;
    logic [2:0]  busy_v;
    logic [2:0]  vld_v;
    logic [2:0]  last_v;
    logic [15:0] re_v [3];
    logic [15:0] im_v [3];

    int          sel;
    int          n_checks;
    int          n_errors;
    logic [32:0] sb_q [$];
    logic [15:0] last_re;
    logic [15:0] last_im;
    logic        hold_pend;
    logic [33:0] held;

    always #5 clk = ~clk;

    twiddle_gen #(.LOG2N(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .k_start(ks[2:0]), .k_step(kp[2:0]),
        .count(cnt[3:0]), .busy(busy_v[0]), .w_valid(vld_v[0]), .w_ready(w_ready),
        .w_re(re_v[0]), .w_im(im_v[0]), .w_last(last_v[0])
`ifdef TWIDDLE_INVERSE_EN
        , .inv(inv_v)
`endif
    );

    twiddle_gen #(.LOG2N(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .k_start(ks[3:0]), .k_step(kp[3:0]),
        .count(cnt[4:0]), .busy(busy_v[1]), .w_valid(vld_v[1]), .w_ready(w_ready),
        .w_re(re_v[1]), .w_im(im_v[1]), .w_last(last_v[1])
`ifdef TWIDDLE_INVERSE_EN
        , .inv(inv_v)
`endif
    );

    twiddle_gen #(.LOG2N(6)) u_d6 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .k_start(ks[5:0]), .k_step(kp[5:0]),
        .count(cnt[6:0]), .busy(busy_v[2]), .w_valid(vld_v[2]), .w_ready(w_ready),
        .w_re(re_v[2]), .w_im(im_v[2]), .w_last(last_v[2])
`ifdef TWIDDLE_INVERSE_EN
        , .inv(inv_v)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Real to fp16, round to nearest; tiny residues of sin/cos count as +0.
    function automatic logic [15:0] to_h(input real x);
        real m;
        int  e;
        int  man;
        logic sgn;
        if (x < 1.0e-9 && x > -1.0e-9) return 16'h0000;
        sgn = (x < 0.0);
        m   = sgn ? -x : x;
        e   = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        man = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (man == 1024) begin man = 0; e++; end
        return {sgn, 5'(e + 15), 10'(man)};
    endfunction

    function automatic logic [32:0] model(input int log2n, input int k, input logic inv, input logic last);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(1 << log2n);
        return {to_h($cos(ang)), to_h(inv ? $sin(ang) : -$sin(ang)), last};
    endfunction

    // Scoreboard and hold-stability monitor on the selected instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check_eq("hold", {vld_v[sel], re_v[sel], im_v[sel], last_v[sel]}, held);
            if (vld_v[sel] && w_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_extra_word", {re_v[sel], im_v[sel], last_v[sel]}, 0);
                end else begin
                    check_eq("word", {re_v[sel], im_v[sel], last_v[sel]}, sb_q.pop_front());
                end
                last_re = re_v[sel];
                last_im = im_v[sel];
            end
            hold_pend = vld_v[sel] && !w_ready;
            held      = {vld_v[sel], re_v[sel], im_v[sel], last_v[sel]};
        end
    end

    // Called just after a rising edge; start is raised immediately, so
    // consecutive calls exercise back-to-back bursts.
    task automatic run_burst(input int s, input int log2n, input int k0, input int kst,
                             input int c, input bit tog, input bit poke);
        int n;
        int n_cyc;
        int first;
        n     = 1 << log2n;
        n_cyc = 0;
        first = -1;
        for (int i = 0; i < c; i++)
            sb_q.push_back(model(log2n, (k0 + i * kst) % n, inv_v, i == c - 1));
        sel        = s;
        ks         = 6'(k0);
        kp         = 6'(kst);
        cnt        = 7'(c);
        w_ready    = 1'b1;
        start_v[s] = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n_cyc++;
            start_v = 3'b000;
            if (tog) w_ready = ((n_cyc % 4) == 0) || ((n_cyc % 4) == 3);
            if (poke && n_cyc == 4) begin
                start_v[s] = 1'b1;
                ks  = 6'd3;
                kp  = 6'd2;
                cnt = 7'd2;
            end
            if (first < 0 && vld_v[s]) first = n_cyc;
        end while (busy_v[s] && n_cyc < 300);
        check_eq("burst_done", busy_v[s], 0);
        if (!tog) begin
            check_eq("first_vld_cycle", first, 2);
            check_eq("burst_len", n_cyc, c + 2);
        end
        check_eq("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        w_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        hold_pend = 1'b0;
        held     = '0;
        last_re  = '0;
        last_im  = '0;
        start_v  = 3'b000;
        ks       = '0;
        kp       = '0;
        cnt      = '0;
        w_ready  = 1'b1;
        inv_v    = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  busy_v[0], 0);
        check_eq("rst_valid", vld_v[0], 0);
        check_eq("rst_last",  last_v[0], 0);
        check_eq("rst_re",    re_v[0], 16'h0000);
        check_eq("rst_im",    im_v[0], 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // N=8 full circle, then immediately a wrapping step-3 burst.
        run_burst(0, 3, 0, 1, 8, 0, 0);
        check_eq("n8_last_word", {last_re, last_im}, {16'h39A8, 16'h39A8});
        run_burst(0, 3, 5, 3, 4, 0, 0);

        // N=64 wrap-around: k = 60, 63, 2.
        run_burst(2, 6, 60, 3, 3, 0, 0);
        check_eq("n64_k2_word", {last_re, last_im}, {16'h3BD9, 16'hB23E});

        // N=16 under 1,0,0,1 backpressure.
        run_burst(1, 4, 5, 1, 16, 1, 0);

        // Start pulsed mid-burst must be ignored.
        run_burst(0, 3, 1, 1, 8, 0, 1);

        // Start with count = 0 must be ignored.
        sel     = 0;
        cnt     = 7'd0;
        start_v = 3'b001;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        repeat (3) begin
            check_eq("cnt0_busy",  busy_v[0], 0);
            check_eq("cnt0_valid", vld_v[0], 0);
            @(posedge clk);
            #1;
        end

        // Single-word burst.
        run_burst(0, 3, 7, 1, 1, 0, 0);

`ifdef TWIDDLE_INVERSE_EN
        inv_v = 1'b1;
        run_burst(0, 3, 2, 1, 1, 0, 0);
        check_eq("inv1_word", {last_re, last_im}, {16'h0000, 16'h3C00});
        run_burst(0, 3, 0, 1, 8, 0, 0);
        inv_v = 1'b0;
        run_burst(0, 3, 2, 1, 1, 0, 0);
        check_eq("inv0_word", {last_re, last_im}, {16'h0000, 16'hBC00});
`endif

        // Reset on the third output cycle of an 8-word burst.
        sel = 0;
        for (int i = 0; i < 8; i++) sb_q.push_back(model(3, i, 1'b0, i == 7));
        ks      = 6'd0;
        kp      = 6'd1;
        cnt     = 7'd8;
        start_v = 3'b001;
        repeat (4) begin
            @(posedge clk);
            #1;
            start_v = 3'b000;
        end
        check_eq("pre_rst_valid", vld_v[0], 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy",  busy_v[0], 0);
        check_eq("mid_rst_valid", vld_v[0], 0);
        check_eq("mid_rst_last",  last_v[0], 0);
        check_eq("mid_rst_re",    re_v[0], 16'h0000);
        check_eq("mid_rst_im",    im_v[0], 16'h0000);
        check_eq("mid_rst_words_left", sb_q.size(), 6);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_valid", vld_v[0], 0);
        end

        // Recovery after reset.
        run_burst(0, 3, 3, 1, 8, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 3, FFT size N = 2^LOG2N; legal range 3..6.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- k_start  input  LOG2N  first twiddle exponent k.
- k_step  input  LOG2N  exponent increment per output.
- count  input  LOG2N+1  number of twiddles in burst, 1..N.
- busy  output  1  high in RUN and DRAIN.
- w_valid  output  1  w_re/w_im/w_last hold valid data.
- w_ready  input  1  consumer accepts the output word.
- w_re  output  16  Re(W_N^k), IEEE-754 half precision.
- w_im  output  16  Im(W_N^k), half precision.
- w_last  output  1  marks the final word of a burst.

Function
REQ-003 SHALL produce W_N^k = cos(2πk/N) - j·sin(2πk/N).
REQ-004 SHALL hold a single quarter-wave ROM C[m] = cos(2πm/64), m = 0..16, fp16 constants (C[0]=0x3C00, C[8]=0x39A8, C[16]=0x0000), regardless of LOG2N.
REQ-005 SHALL split k into q = k[LOG2N-1:LOG2N-2] and r = k mod N/4, and read C at address a = r·(64/N) and b = (N/4 - r)·(64/N).
REQ-006 SHALL fold by quadrant: q0 re=C[a], im=-C[b]; q1 re=-C[b], im=-C[a]; q2 re=-C[a], im=C[b]; q3 re=C[b], im=C[a].
REQ-007 SHALL negate by inverting bit 15; a negated zero SHALL be emitted as 0x0000, never 0x8000.
REQ-008 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-009 SHALL, in IDLE with start=1 and count≠0, capture k_start, k_step and count, and enter RUN next cycle; start with count=0 SHALL be ignored.
REQ-010 SHALL ignore start while busy=1.
REQ-011 SHALL, in RUN, issue one exponent per advancing cycle, k ← (k + k_step) mod N (wrap-around), remaining ← remaining - 1.
REQ-012 SHALL enter DRAIN after issuing the last exponent, and return to IDLE in the cycle after the w_last word handshakes (w_valid & w_ready).
REQ-013 SHALL be a 2-stage pipeline: stage 1 registers q, a, b and last; stage 2 registers the folded result into the outputs; the first w_valid SHALL assert 2 cycles after the start cycle.
REQ-014 SHALL advance all stages and the sequencer only when adv = !w_valid | w_ready; when adv=0, every output SHALL hold stable.
REQ-015 SHALL sustain one word per cycle with w_ready held high; a burst of count words SHALL complete in count+2 cycles.
REQ-016 SHALL assert w_last together with the word of the final issued exponent only.
REQ-017 SHALL accept a new start in the first IDLE cycle after DRAIN (back-to-back bursts).

Reset
REQ-018 SHALL, on rst_n=0, immediately force FSM=IDLE, busy=0, w_valid=0, w_last=0, w_re=0x0000, w_im=0x0000, and clear all pipeline valids.
REQ-019 SHALL abort any burst in progress on reset; no partial word SHALL appear after rst_n deasserts.

Configuration
REQ-020 SHALL, when macro TWIDDLE_INVERSE_EN is defined, add input port inv (1 bit), captured at start; with inv=1, every word of that burst SHALL be the conjugate (w_im negated per REQ-007).
REQ-021 SHALL, when TWIDDLE_INVERSE_EN is undefined, omit port inv and produce forward twiddles only.

Verification
REQ-022 LOG2N=3, k_start=0, k_step=1, count=8, w_ready=1 -> (re,im) = (3C00,0000),(39A8,B9A8),(0000,BC00),(B9A8,B9A8),(BC00,0000),(B9A8,39A8),(0000,3C00),(39A8,39A8); w_last on 8th; busy low after cycle 10.
REQ-023 LOG2N=6, k_start=60, k_step=3, count=3 -> k = 60, 63, 2 (wrap-around); w_re(k=2)=C[2], w_im(k=2)=C[14] negated.
REQ-024 LOG2N=4, count=16, w_ready toggled 1,0,0,1 repeating -> 16 words in order, none lost or duplicated; outputs stable while w_ready=0.
REQ-025 start pulsed mid-burst and with count=0 in IDLE -> both ignored; busy and output sequence unchanged.
REQ-026 rst_n low on the 3rd output cycle of an 8-word burst -> all outputs 0 immediately; after release, w_valid stays 0 until a new start.
REQ-027 TWIDDLE_INVERSE_EN defined, LOG2N=3, inv=1, k_start=2, count=1 -> (0000,3C00); inv=0 -> (0000,BC00).
